// File: rtl/thor2022_bfins_pkg.sv
// Shared Thor2022 types used by the bitfield units.
package Thor2022_pkg;

    localparam int VALUE_W = 128;

    typedef logic [VALUE_W-1:0] Value;

    typedef enum logic [1:0] {
        BFINS  = 2'd0,
        BFINSI = 2'd1,
        BFDEP  = 2'd2,
        BFRSV  = 2'd3
    } bfins_op_t;

endpackage

// File: rtl/thor2022_bfmask.sv
// Bitfield mask generator: bits mb..mb+mw set, computed in 8-bit arithmetic and
// truncated at the top of the word (never wraps).
module thor2022_bfmask #(
    parameter int WID = 128
) (
    input  logic [6:0]     mb_i,
    input  logic [6:0]     mw_i,
    output logic [WID-1:0] m_o
);

    logic [7:0] hi;

    always_comb begin
        hi = {1'b0, mb_i} + {1'b0, mw_i};
        for (int n = 0; n < WID; n++) begin
            m_o[n] = (8'(n) >= {1'b0, mb_i}) && (8'(n) <= hi);
        end
    end

endmodule

// File: rtl/thor2022_bfins.sv
// Two-stage bitfield insert/deposit unit with valid/ready flow control.
// Optional source-overflow flag enabled by defining THOR2022_BFINS_OVF_EN.
module thor2022_bfins
    import Thor2022_pkg::*;
#(
    parameter int WID  = 128,
    parameter int TAGW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [WID-1:0]  a_i,
    input  logic [WID-1:0]  d_i,
    input  logic [7:0]      imm_i,
    input  logic [6:0]      mb_i,
    input  logic [6:0]      mw_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [WID-1:0]  o_o,
    output logic [TAGW-1:0] tag_o,
    output logic            ovf_o
);

    bfins_op_t       op_in;
    logic [WID-1:0]  src, m_d, sh_d, o2_d;
    logic            v1_q, v2_q, adv2, ld1;
    logic [WID-1:0]  m1_q, sh1_q, a1_q, o2_q;
    bfins_op_t       op1_q;
    logic [TAGW-1:0] tag1_q, tag2_q;

    assign op_in = bfins_op_t'(op_i);
    assign src   = (op_in == BFINSI) ? {{(WID-8){imm_i[7]}}, imm_i} : d_i;
    assign sh_d  = src << mb_i;

    thor2022_bfmask #(.WID(WID)) u_mask (
        .mb_i (mb_i),
        .mw_i (mw_i),
        .m_o  (m_d)
    );

    assign adv2       = ~v2_q | out_ready_i;
    assign ld1        = ~v1_q | adv2;
    assign in_ready_o = ~v1_q | ~v2_q | out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (ld1)  v1_q <= in_valid_i;
            if (adv2) v2_q <= v1_q;
        end
    end

    // Stage 1: mask, shifted source and operands
    always_ff @(posedge clk_i) begin
        if (ld1 && in_valid_i) begin
            m1_q   <= m_d;
            sh1_q  <= sh_d;
            a1_q   <= a_i;
            op1_q  <= op_in;
            tag1_q <= tag_i;
        end
    end

    always_comb begin
        o2_d = a1_q;
        case (op1_q)
            BFINS, BFINSI: o2_d = (a1_q & ~m1_q) | (sh1_q & m1_q);
            BFDEP:         o2_d = sh1_q & m1_q;
            default:       o2_d = a1_q;
        endcase
    end

    // Stage 2: merged result, held while the consumer stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            o2_q   <= '0;
            tag2_q <= '0;
        end else if (adv2 && v1_q) begin
            o2_q   <= o2_d;
            tag2_q <= tag1_q;
        end
    end

    assign out_valid_o = v2_q;
    assign o_o         = o2_q;
    assign tag_o       = tag2_q;

`ifdef THOR2022_BFINS_OVF_EN
    logic [WID-1:0] lo_m, ext;
    logic           fit, ovf1_d, ovf1_q, ovf2_q;

    thor2022_bfmask #(.WID(WID)) u_lowmask (
        .mb_i (7'd0),
        .mw_i (mw_i),
        .m_o  (lo_m)
    );

    // Signed immediates fit when every bit above the field top matches its sign bit
    assign ext    = (op_in == BFINSI && src[mw_i]) ? ~src : src;
    assign fit    = ((ext & ~lo_m) == '0) && (({1'b0, mb_i} + {1'b0, mw_i}) <= 8'(WID-1));
    assign ovf1_d = (op_in != BFRSV) && !fit;

    always_ff @(posedge clk_i) begin
        if (ld1 && in_valid_i) ovf1_q <= ovf1_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              ovf2_q <= 1'b0;
        else if (adv2 && v1_q)  ovf2_q <= ovf1_q;
    end

    assign ovf_o = ovf2_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_thor2022_bfins.sv
// Table-driven and scoreboard bench for the bitfield insert/deposit unit.
module tb_thor2022_bfins;

    localparam int WID  = 128;
    localparam int TAGW = 4;
`ifdef THOR2022_BFINS_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]      op;
        logic [WID-1:0]  a;
        logic [WID-1:0]  d;
        logic [7:0]      imm;
        logic [6:0]      mb;
        logic [6:0]      mw;
        logic [TAGW-1:0] tag;
        logic [WID-1:0]  eo;
        logic            eovf;
    } vec_t;

    typedef struct {
        logic [WID-1:0]  o;
        logic [TAGW-1:0] tag;
        logic            ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            in_valid_i, in_ready_o, out_valid_o, out_ready_i, ovf_o;
    logic [1:0]      op_i;
    logic [WID-1:0]  a_i, d_i, o_o;
    logic [7:0]      imm_i;
    logic [6:0]      mb_i, mw_i;
    logic [TAGW-1:0] tag_i, tag_o;

    always #5 clk = ~clk;

    thor2022_bfins #(.WID(WID), .TAGW(TAGW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .d_i         (d_i),
        .imm_i       (imm_i),
        .mb_i        (mb_i),
        .mw_i        (mw_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .o_o         (o_o),
        .tag_o       (tag_o),
        .ovf_o       (ovf_o)
    );

    exp_t           q[$];
    exp_t           cur_exp;
    int             checks = 0;
    int             errs   = 0;
    int             npop   = 0;
    bit             saw_out, acc, hold_pend;
    logic [WID-1:0] hold_o;
    logic [TAGW-1:0] hold_tag;
    vec_t           tbl[10];

    task automatic chk(input string name, input logic [WID-1:0] got, input logic [WID-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Bit-by-bit reference: walk the field and copy source bits one at a time.
    function automatic exp_t model(input vec_t v);
        exp_t           e;
        logic [WID-1:0] src;
        int             top;
        bit             bad;
        src   = (v.op == 2'd1) ? {{(WID-8){v.imm[7]}}, v.imm} : v.d;
        e.tag = v.tag;
        e.ovf = 1'b0;
        if (v.op == 2'd3) begin
            e.o = v.a;
            return e;
        end
        e.o = (v.op == 2'd2) ? '0 : v.a;
        top = int'(v.mb) + int'(v.mw);
        for (int n = 0; n < WID; n++)
            if (n >= int'(v.mb) && n <= top) e.o[n] = src[n - int'(v.mb)];
        bad = (top > WID - 1);
        for (int k = int'(v.mw) + 1; k < WID; k++)
            if (v.op == 2'd1) bad |= (src[k] != src[v.mw]);
            else              bad |= src[k];
        e.ovf = OVF_ON & bad;
        return e;
    endfunction

    task automatic set_in(input vec_t v);
        op_i  = v.op;
        a_i   = v.a;
        d_i   = v.d;
        imm_i = v.imm;
        mb_i  = v.mb;
        mw_i  = v.mw;
        tag_i = v.tag;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        saw_out = 1'b0;
        acc     = 1'b0;
        chkb("in_ready", in_ready_o, (q.size() < 2) || out_ready_i);
        if (hold_pend) begin
            chkb("hold_valid", out_valid_o, 1'b1);
            chk("hold_o", o_o, hold_o);
            chk("hold_tag", {{(WID-TAGW){1'b0}}, tag_o}, {{(WID-TAGW){1'b0}}, hold_tag});
        end
        if (out_valid_o && out_ready_i) begin
            saw_out = 1'b1;
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_out got tag %h expected no result", tag_o);
            end else begin
                e = q.pop_front();
                npop++;
                chk("result_o", o_o, e.o);
                chk("result_tag", {{(WID-TAGW){1'b0}}, tag_o}, {{(WID-TAGW){1'b0}}, e.tag});
                chkb("result_ovf", ovf_o, e.ovf);
            end
        end
        hold_pend = out_valid_o && !out_ready_i;
        hold_o    = o_o;
        hold_tag  = tag_o;
        if (in_valid_i && in_ready_o) begin
            acc = 1'b1;
            q.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input vec_t v);
        int lat;
        set_in(v);
        cur_exp     = '{o: v.eo, tag: v.tag, ovf: OVF_ON & v.eovf};
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        step();
        chkb("accept", acc, 1'b1);
        in_valid_i = 1'b0;
        lat = 0;
        do begin
            lat++;
            step();
        end while (!saw_out && lat < 10);
        chki("latency", lat, 2);
    endtask

    initial begin
        int   cyc, sent, npop0;
        vec_t sv[8];

        tbl[0] = '{2'd0, ~128'h0, 128'h0, 8'h00, 7'd8, 7'd7, 4'h5, ~128'hFF00, 1'b0};
        tbl[1] = '{2'd1, 128'h0, 128'h0, 8'hFD, 7'd4, 7'd3, 4'h6, 128'hD0, 1'b0};
        tbl[2] = '{2'd2, 128'hFFFF, 128'h1F, 8'h00, 7'd124, 7'd7, 4'h7, {4'hF, 124'h0}, 1'b1};
        tbl[3] = '{2'd0, {32{4'h5}}, 128'h0123456789ABCDEF_FEDCBA9876543210, 8'h00, 7'd0, 7'd127, 4'h8,
                   128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0};
        tbl[4] = '{2'd3, 128'hDEADBEEF_00112233_44556677_8899AABB, 128'hFFFF, 8'h55, 7'd10, 7'd3, 4'h9,
                   128'hDEADBEEF_00112233_44556677_8899AABB, 1'b0};
        tbl[5] = '{2'd0, 128'h0, 128'h1, 8'h00, 7'd127, 7'd5, 4'hA, {1'b1, 127'h0}, 1'b1};
        tbl[6] = '{2'd0, 128'h0, 128'h100, 8'h00, 7'd0, 7'd7, 4'hB, 128'h0, 1'b1};
        tbl[7] = '{2'd1, 128'hFFFF, 128'h0, 8'h7F, 7'd0, 7'd3, 4'hC, 128'hFFFF, 1'b1};
        tbl[8] = '{2'd2, ~128'h0, 128'hAB, 8'h00, 7'd16, 7'd7, 4'hD, 128'hAB0000, 1'b0};
        tbl[9] = '{2'd1, 128'h0, 128'h0, 8'h80, 7'd120, 7'd7, 4'hE, {8'h80, 120'h0}, 1'b0};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        hold_pend   = 1'b0;
        set_in(tbl[0]);
        cur_exp = '{o: '0, tag: '0, ovf: 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_o", o_o, '0);
        chk("rst_tag", {{(WID-TAGW){1'b0}}, tag_o}, '0);
        chkb("rst_ovf", ovf_o, 1'b0);
        rst_i = 1'b0;
        #1;
        chkb("rst_in_ready", in_ready_o, 1'b1);

        for (int i = 0; i < 10; i++) run_one(tbl[i]);

        // Back-to-back issue with the consumer always ready: one accept per cycle
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(tbl[i]);
            cur_exp    = '{o: tbl[i].eo, tag: tbl[i].tag, ovf: OVF_ON & tbl[i].eovf};
            in_valid_i = 1'b1;
            step();
            chkb("nobubble_accept", acc, 1'b1);
        end
        in_valid_i = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chki("nobubble_drain", q.size(), 0);

        // Stream of 8 random ops against a 1,0,0 consumer pattern
        for (int i = 0; i < 8; i++) begin
            sv[i].op  = 2'($urandom_range(0, 3));
            sv[i].a   = {$urandom, $urandom, $urandom, $urandom};
            sv[i].d   = {$urandom, $urandom, $urandom, $urandom};
            sv[i].imm = 8'($urandom);
            sv[i].mb  = 7'($urandom_range(0, 127));
            sv[i].mw  = 7'($urandom_range(0, 127));
            sv[i].tag = 4'(i);
            sv[i].eo  = '0;
            sv[i].eovf = 1'b0;
        end
        npop0 = npop;
        sent  = 0;
        cyc   = 0;
        while ((sent < 8 || q.size() > 0) && cyc < 300) begin
            out_ready_i = (cyc % 3 == 0);
            if (sent < 8) begin
                set_in(sv[sent]);
                cur_exp    = model(sv[sent]);
                in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid_i = 1'b0;
        chki("stream_count", npop - npop0, 8);
        chki("stream_sent", sent, 8);

        // Reset with two operations in flight and the consumer stalled
        out_ready_i = 1'b0;
        set_in(tbl[3]);
        cur_exp    = '{o: tbl[3].eo, tag: tbl[3].tag, ovf: OVF_ON & tbl[3].eovf};
        in_valid_i = 1'b1;
        step();
        set_in(tbl[8]);
        cur_exp = '{o: tbl[8].eo, tag: tbl[8].tag, ovf: OVF_ON & tbl[8].eovf};
        step();
        in_valid_i = 1'b0;
        chkb("inflight_valid", out_valid_o, 1'b1);
        chkb("inflight_full_stall", in_ready_o, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        chkb("midrst_out_valid", out_valid_o, 1'b0);
        chk("midrst_o", o_o, '0);
        chk("midrst_tag", {{(WID-TAGW){1'b0}}, tag_o}, '0);
        q.delete();
        hold_pend = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        chkb("midrst_in_ready", in_ready_o, 1'b1);
        run_one(tbl[1]);
        chki("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
